demux_lanes: RTL and testbench

Registered 1-to-8 demultiplexer, the write-side counterpart of the team's 8-to-1 select mux. It takes one stream of 3-bit words with a valid/ready handshake and steers each word into one of eight per-lane holding registers. The destination is either an explicit select or an internal round-robin pointer. Each lane presents its word downstream with its own valid/ready handshake. Empty lanes drive the idle value all-ones, matching the mux default output.

---
 rtl/demux_lanes_pkg.sv | 14 +
 rtl/demux_lane_reg.sv | 35 +++
 rtl/demux_lanes.sv | 80 ++++++++
 tb/tb_demux_lanes.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_lanes_pkg.sv
// Shared defaults and helpers for the 1-to-N lane demultiplexer.
// Lane k of a packed lane bus lives at bits [lane_base(k, WIDTH) +: WIDTH].
package demux_lanes_pkg;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_LANES = 8;
    localparam int DEF_SEL_W = 3;
    localparam logic [DEF_WIDTH-1:0] DEF_IDLE = '1;

    function automatic int lane_base(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// Single-entry lane holding register: load wins over drain, idle value shown when empty.
// Latency 1 cycle from load to valid; stalls nothing itself, upstream checks valid/drain_ready.
module demux_lane_reg
    import demux_lanes_pkg::*;
#(
    parameter int                WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0]  IDLE_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] store;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            store <= IDLE_VALUE;
        end else if (load) begin
            valid <= 1'b1;
            store <= load_data;
        end else if (valid && drain_ready) begin
            valid <= 1'b0;
        end
    end

    // Storage is not cleared on drain; empty lanes are masked here instead.
    assign data = valid ? store : IDLE_VALUE;

endmodule

// File: rtl/demux_lanes.sv
// Registered 1-to-LANES demux steering words by explicit select or round-robin pointer.
// Latency 1 cycle; in_ready drops only when the target lane is full and not draining, or out of range.
module demux_lanes
    import demux_lanes_pkg::*;
#(
    parameter int                WIDTH      = DEF_WIDTH,
    parameter int                LANES      = DEF_LANES,
    parameter int                SEL_W      = DEF_SEL_W,
    parameter logic [WIDTH-1:0]  IDLE_VALUE = {WIDTH{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_auto,
    output logic [LANES-1:0]       out_valid,
    input  logic [LANES-1:0]       out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [SEL_W-1:0]       rr_ptr,
    output logic                   busy
);

    localparam logic [SEL_W:0]   LANES_LIM = (SEL_W+1)'(LANES);
    localparam logic [SEL_W-1:0] RR_LAST   = SEL_W'(LANES - 1);

    logic [SEL_W-1:0] tsel;
    logic             lane_free;
    logic             accept;
    logic [LANES-1:0] load;

    assign tsel = in_auto ? rr_ptr : in_sel;

    // Out-of-range selects match no lane, so lane_free stays 0 and the word stalls.
    always_comb begin
        lane_free = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (tsel == SEL_W'(k)) begin
                lane_free = !out_valid[k] || out_ready[k];
            end
        end
    end

    assign in_ready = ({1'b0, tsel} < LANES_LIM) && lane_free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < LANES; k++) begin
            load[k] = accept && (tsel == SEL_W'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept && in_auto) begin
            rr_ptr <= (rr_ptr == RR_LAST) ? '0 : rr_ptr + 1'b1;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        demux_lane_reg #(
            .WIDTH      (WIDTH),
            .IDLE_VALUE (IDLE_VALUE)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .load        (load[k]),
            .load_data   (in_data),
            .drain_ready (out_ready[k]),
            .valid       (out_valid[k]),
            .data        (out_data[lane_base(k, WIDTH) +: WIDTH])
        );
    end

    assign busy = |out_valid;

endmodule

// File: tb/tb_demux_lanes.sv
// Scenario and randomized bench for demux_lanes against a lane-array reference model.
module tb_demux_lanes;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_data;
    logic [2:0]  in_sel;
    logic        in_auto;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [23:0] out_data;
    logic [2:0]  rr_ptr;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    bit         mv[8];
    logic [2:0] md[8];
    int         rr;

    demux_lanes dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_auto   (in_auto),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rr_ptr    (rr_ptr),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int target();
        return in_auto ? rr : int'(in_sel);
    endfunction

    function automatic logic exp_ready();
        int t;
        t = target();
        if (t >= 8) return 1'b0;
        return !mv[t] || out_ready[t];
    endfunction

    function automatic logic [7:0] exp_valid();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = mv[k];
        return v;
    endfunction

    function automatic logic [23:0] exp_data();
        logic [23:0] d;
        for (int k = 0; k < 8; k++) d[k*3 +: 3] = mv[k] ? md[k] : 3'b111;
        return d;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            mv[k] = 1'b0;
            md[k] = 3'b111;
        end
        rr = 0;
    endtask

    task automatic drive(input logic v, input logic auto_m, input logic [2:0] sel,
                         input logic [2:0] dat, input logic [7:0] rdy);
        in_valid  = v;
        in_auto   = auto_m;
        in_sel    = sel;
        in_data   = dat;
        out_ready = rdy;
        #1;
    endtask

    // Advance one clock and apply the accept/drain rules to the model.
    task automatic tick();
        int t;
        bit acc;
        t   = target();
        acc = in_valid && exp_ready();
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            if (acc && t == k) begin
                mv[k] = 1'b1;
                md[k] = in_data;
            end else if (mv[k] && out_ready[k]) begin
                mv[k] = 1'b0;
            end
        end
        if (acc && in_auto) rr = (rr + 1) % 8;
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 8'h00);
        checks++; if (out_valid !== 8'h00) begin failures++; $display("FAIL reset_valid got=%h exp=00", out_valid); end
        checks++; if (out_data !== 24'hFFFFFF) begin failures++; $display("FAIL reset_data got=%h exp=ffffff", out_data); end
        checks++; if (rr_ptr !== 3'd0) begin failures++; $display("FAIL reset_rr got=%0d exp=0", rr_ptr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_explicit();
        drive(1'b1, 1'b0, 3'd5, 3'b010, 8'h00);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL expl_ready got=%b exp=1", in_ready); end
        tick();
        drive(1'b0, 1'b0, 3'd5, 3'b000, 8'h00);
        checks++; if (out_valid !== 8'b0010_0000) begin failures++; $display("FAIL expl_valid got=%b exp=00100000", out_valid); end
        checks++; if (out_data !== 24'b111_111_010_111_111_111_111_111) begin failures++; $display("FAIL expl_data got=%h exp=%h", out_data, 24'b111_111_010_111_111_111_111_111); end
        checks++; if (rr_ptr !== 3'd0) begin failures++; $display("FAIL expl_rr got=%0d exp=0", rr_ptr); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL expl_busy got=%b exp=1", busy); end
    endtask

    task automatic test_target_full();
        drive(1'b1, 1'b0, 3'd5, 3'b001, 8'h00);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_stall got=%b exp=0", in_ready); end
        tick();
        checks++; if (out_data[15 +: 3] !== 3'b010) begin failures++; $display("FAIL full_hold got=%b exp=010", out_data[15 +: 3]); end
        drive(1'b1, 1'b0, 3'd5, 3'b001, 8'b0010_0000);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_release got=%b exp=1", in_ready); end
        tick();
        drive(1'b0, 1'b0, 3'd5, 3'b000, 8'h00);
        checks++; if (out_valid[5] !== 1'b1) begin failures++; $display("FAIL load_beats_drain_valid got=%b exp=1", out_valid[5]); end
        checks++; if (out_data[15 +: 3] !== 3'b001) begin failures++; $display("FAIL load_beats_drain_data got=%b exp=001", out_data[15 +: 3]); end
    endtask

    task automatic test_independence();
        drive(1'b1, 1'b0, 3'd2, 3'b100, 8'h00);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL indep_ready got=%b exp=1", in_ready); end
        tick();
        drive(1'b0, 1'b0, 3'd0, 3'b000, 8'h00);
        checks++; if (out_valid !== 8'b0010_0100) begin failures++; $display("FAIL indep_valid got=%b exp=00100100", out_valid); end
        checks++; if (out_data !== exp_data()) begin failures++; $display("FAIL indep_data got=%h exp=%h", out_data, exp_data()); end
    endtask

    task automatic test_rr_wrap();
        for (int n = 0; n < 10; n++) begin
            drive(1'b1, 1'b1, 3'd0, 3'(n % 8), 8'hFF);
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rr_ready n=%0d got=%b exp=1", n, in_ready); end
            checks++; if (rr_ptr !== 3'(n % 8)) begin failures++; $display("FAIL rr_seq n=%0d got=%0d exp=%0d", n, rr_ptr, n % 8); end
            tick();
            checks++; if (out_valid[n % 8] !== 1'b1 || out_data[(n % 8)*3 +: 3] !== 3'(n % 8)) begin
                failures++; $display("FAIL rr_lane n=%0d valid=%b data=%0d exp_data=%0d", n, out_valid[n % 8], out_data[(n % 8)*3 +: 3], n % 8);
            end
        end
        checks++; if (rr_ptr !== 3'd2) begin failures++; $display("FAIL rr_final got=%0d exp=2", rr_ptr); end
        drive(1'b0, 1'b1, 3'd0, 3'd0, 8'hFF);
        tick();
        checks++; if (out_valid !== 8'h00) begin failures++; $display("FAIL rr_drained got=%b exp=00000000", out_valid); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 3'd0, 3'b011, 8'h00); tick();
        drive(1'b1, 1'b0, 3'd3, 3'b101, 8'h00); tick();
        drive(1'b1, 1'b0, 3'd7, 3'b110, 8'h00); tick();
        drive(1'b0, 1'b0, 3'd0, 3'b000, 8'h00);
        checks++; if (out_valid !== 8'b1000_1001) begin failures++; $display("FAIL pre_reset_valid got=%b exp=10001001", out_valid); end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (out_valid !== 8'h00) begin failures++; $display("FAIL async_valid got=%b exp=00", out_valid); end
        checks++; if (out_data !== 24'hFFFFFF) begin failures++; $display("FAIL async_data got=%h exp=ffffff", out_data); end
        checks++; if (rr_ptr !== 3'd0) begin failures++; $display("FAIL async_rr got=%0d exp=0", rr_ptr); end
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 3'd3, 3'b001, 8'h00);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", in_ready); end
        tick();
        drive(1'b0, 1'b0, 3'd0, 3'b000, 8'h00);
        checks++; if (out_valid !== 8'b0000_1000 || out_data[9 +: 3] !== 3'b001) begin
            failures++; $display("FAIL post_reset_accept valid=%b data=%b exp_valid=00001000 exp_data=001", out_valid, out_data[9 +: 3]);
        end
    endtask

    task automatic test_switch();
        for (int n = 0; n < 4; n++) begin
            drive(1'b1, 1'b1, 3'd0, 3'b000, 8'hFF);
            tick();
        end
        checks++; if (rr_ptr !== 3'd4) begin failures++; $display("FAIL sw_rr_setup got=%0d exp=4", rr_ptr); end
        drive(1'b1, 1'b0, 3'd1, 3'b110, 8'h00);
        checks++; if (in_ready !== exp_ready()) begin failures++; $display("FAIL sw_ready got=%b exp=%b", in_ready, exp_ready()); end
        tick();
        drive(1'b0, 1'b0, 3'd0, 3'b000, 8'h00);
        checks++; if (out_valid[1] !== 1'b1 || out_data[3 +: 3] !== 3'b110) begin
            failures++; $display("FAIL sw_lane1 valid=%b data=%b exp=1/110", out_valid[1], out_data[3 +: 3]);
        end
        checks++; if (out_valid[4] !== 1'b0) begin failures++; $display("FAIL sw_lane4 got=%b exp=0", out_valid[4]); end
        checks++; if (rr_ptr !== 3'd4) begin failures++; $display("FAIL sw_rr_hold got=%0d exp=4", rr_ptr); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 3'($urandom),
                  3'($urandom), 8'($urandom));
            checks++; if (in_ready !== exp_ready()) begin failures++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, in_ready, exp_ready()); end
            tick();
            checks++; if (out_valid !== exp_valid()) begin failures++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, out_valid, exp_valid()); end
            checks++; if (out_data !== exp_data()) begin failures++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, out_data, exp_data()); end
            checks++; if (rr_ptr !== 3'(rr)) begin failures++; $display("FAIL rnd_rr i=%0d got=%0d exp=%0d", i, rr_ptr, rr); end
            checks++; if (busy !== (exp_valid() != 8'h00)) begin failures++; $display("FAIL rnd_busy i=%0d got=%b", i, busy); end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_auto   = 1'b0;
        in_sel    = 3'd0;
        in_data   = 3'd0;
        out_ready = 8'h00;
        #7;
        test_reset();
        test_explicit();
        test_target_full();
        test_independence();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 8'hFF);
        tick();
        test_rr_wrap();
        test_reset_mid();
        test_switch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
